// File: rtl/camera_config_sequencer_pkg.sv
// Shared definitions for the OV7670 configuration sequencer.
//   - ENTRY_W / REG_W : table entry width and SCCB register byte width
//   - END_CODE        : end-of-table marker
//   - DELAY_CODE      : inline delay entry
//   - TBL_*           : mode table identifiers
//   - seq_state_e     : sequencer FSM states
package camera_config_sequencer_pkg;

    localparam int ENTRY_W = 16;
    localparam int REG_W   = 8;

    localparam logic [ENTRY_W-1:0] END_CODE   = 16'hFFFF;
    localparam logic [ENTRY_W-1:0] DELAY_CODE = 16'hFFF0;

    localparam int TBL_RGB565_VGA = 0;
    localparam int TBL_YUV_QVGA   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/camera_config_sequencer_if.sv
// Register-write command channel between the configuration sequencer and
// the SCCB master.
//   cmd_valid : a write is pending (master -> slave)
//   cmd_ready : the SCCB master accepts the write (slave -> master)
//   cmd_addr  : OV7670 sub-address
//   cmd_data  : register value
interface camera_config_sequencer_if;
    import camera_config_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [REG_W-1:0] cmd_addr;
    logic [REG_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/camera_config_table.sv
// Synchronous-read ROM holding the OV7670 mode tables.
//   clk  : read clock
//   addr : {table id, entry index}
//   dout : {sub-address, value} entry, valid one cycle after addr
// Entries not listed in a table (and unknown tables) read as END_CODE.
module camera_config_table
    import camera_config_sequencer_pkg::*;
#(
    parameter int                 IDX_W      = 8,
    parameter int                 SEL_W      = 1,
    parameter logic [ENTRY_W-1:0] END_CODE   = camera_config_sequencer_pkg::END_CODE,
    parameter logic [ENTRY_W-1:0] DELAY_CODE = camera_config_sequencer_pkg::DELAY_CODE
) (
    input  logic                   clk,
    input  logic [SEL_W+IDX_W-1:0] addr,
    output logic [ENTRY_W-1:0]     dout
);

    logic [31:0]        tbl_id;
    logic [31:0]        entry_idx;
    logic [ENTRY_W-1:0] rom_word;

    assign tbl_id    = 32'(addr[SEL_W+IDX_W-1:IDX_W]);
    assign entry_idx = 32'(addr[IDX_W-1:0]);

    always_comb begin
        rom_word = END_CODE;
        if (tbl_id == TBL_RGB565_VGA) begin
            case (entry_idx)
                0:       rom_word = 16'h1280;   // COM7: soft reset
                1:       rom_word = DELAY_CODE; // let the sensor come out of reset
                2:       rom_word = DELAY_CODE;
                3:       rom_word = 16'h1204;   // COM7: VGA, RGB
                4:       rom_word = 16'h1101;   // CLKRC: prescaler
                5:       rom_word = 16'h0C00;   // COM3: no scaling
                6:       rom_word = 16'h3E00;   // COM14: normal PCLK
                7:       rom_word = 16'h40D0;   // COM15: RGB565, full range
                8:       rom_word = 16'h8C00;   // RGB444 off
                9:       rom_word = 16'h3A04;   // TSLB
                10:      rom_word = 16'h13E5;   // COM8: AGC/AEC on
                default: rom_word = END_CODE;
            endcase
        end else if (tbl_id == TBL_YUV_QVGA) begin
            case (entry_idx)
                0:       rom_word = 16'h1280;   // COM7: soft reset
                1:       rom_word = DELAY_CODE;
                2:       rom_word = 16'h1200;   // COM7: YUV
                3:       rom_word = 16'h0C04;   // COM3: enable scaling
                4:       rom_word = 16'h3E19;   // COM14: PCLK divide for QVGA
                5:       rom_word = 16'h7211;   // SCALING_DCWCTR
                6:       rom_word = 16'h73F1;   // SCALING_PCLK_DIV
                7:       rom_word = 16'h3A04;   // TSLB
                8:       rom_word = 16'h13E5;   // COM8
                default: rom_word = END_CODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        dout <= rom_word;
    end

endmodule

// File: rtl/camera_config_sequencer.sv
// OV7670 configuration sequencer. On an accepted start it walks the
// selected register table, hands each write to the SCCB master over a
// valid/ready handshake, waits DELAY_CYCLES on delay entries and stops at
// the end marker (or with err set if the table has no end marker).
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a pass (honoured only in IDLE/DONE)
//   table_sel : table to walk, latched on an accepted start
//   cmd       : command channel to the SCCB master
//   busy      : pass in progress
//   done      : pass finished, held until the next accepted start
//   index     : current table index
//   err       : invalid table or missing end marker
module camera_config_sequencer
    import camera_config_sequencer_pkg::*;
#(
    parameter int                 IDX_W        = 8,
    parameter int                 NUM_TABLES   = 2,
    parameter int                 SEL_W        = 1,
    parameter int                 DELAY_CYCLES = 1_000_000,
    parameter logic [ENTRY_W-1:0] END_CODE     = camera_config_sequencer_pkg::END_CODE,
    parameter logic [ENTRY_W-1:0] DELAY_CODE   = camera_config_sequencer_pkg::DELAY_CODE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SEL_W-1:0]          table_sel,
    camera_config_sequencer_if.master cmd,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          index,
    output logic                      err
);

    localparam int               CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    seq_state_e         state_q, state_d;
    logic [SEL_W-1:0]   table_q, table_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [ENTRY_W-1:0] rom_dout;
    logic               advance;
    logic               sel_bad;

    camera_config_table #(
        .IDX_W      (IDX_W),
        .SEL_W      (SEL_W),
        .END_CODE   (END_CODE),
        .DELAY_CODE (DELAY_CODE)
    ) u_table (
        .clk  (clk),
        .addr ({table_q, index_q}),
        .dout (rom_dout)
    );

    assign sel_bad = (32'(table_sel) >= 32'(NUM_TABLES));

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    table_d = table_sel;
                    index_d = '0;
                    err_d   = sel_bad;
                    state_d = sel_bad ? ST_DONE : ST_FETCH;
                end
            end
            // ROM address is {table_q, index_q}; its output is ready in DECODE.
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_dout == END_CODE) begin
                    state_d = ST_DONE;
                end else if (rom_dout == DELAY_CODE) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_DELAY;
                end else begin
                    addr_d  = rom_dout[15:8];
                    data_d  = rom_dout[7:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND:  advance = cmd.cmd_ready;
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Running off the last entry is an error; the index never wraps.
        if (advance) begin
            if (index_q == LAST_IDX) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
            end else begin
                index_d = index_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            table_q <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign cmd.cmd_valid = (state_q == ST_SEND);
    assign cmd.cmd_addr  = addr_q;
    assign cmd.cmd_data  = data_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign index         = index_q;
    assign err           = err_q;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer. Three instances: a default one (main),
// one with IDX_W=3 so the tables have no end marker in range (short), and
// one with NUM_TABLES=1 (one_tbl). An entry-level model walks the expected
// table contents and derives each cycle's outputs from the timing rules.
module tb_camera_config_sequencer;

    localparam int DLY = 4;

    localparam logic [15:0] REF0 [0:10] = '{16'h1280, 16'hFFF0, 16'hFFF0, 16'h1204, 16'h1101,
                                            16'h0C00, 16'h3E00, 16'h40D0, 16'h8C00, 16'h3A04,
                                            16'h13E5};
    localparam logic [15:0] REF1 [0:8]  = '{16'h1280, 16'hFFF0, 16'h1200, 16'h0C04, 16'h3E19,
                                            16'h7211, 16'h73F1, 16'h3A04, 16'h13E5};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_v [3];
    logic [0:0] sel_v   [3];
    logic       ready_v [3];
    logic       valid_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       err_v   [3];
    logic [7:0] addr_v  [3];
    logic [7:0] data_v  [3];
    logic [7:0] idx_v   [3];

    logic [7:0] index_m;
    logic [2:0] index_s;
    logic [7:0] index_i;

    int    max_v  [3] = '{256, 8, 256};
    int    ntab_v [3] = '{2, 2, 1};
    string dn     [3] = '{"main", "short", "one_tbl"};

    int n_checks = 0;
    int n_pass   = 0;

    camera_config_sequencer_if bus_m ();
    camera_config_sequencer_if bus_s ();
    camera_config_sequencer_if bus_i ();

    camera_config_sequencer #(.IDX_W(8), .NUM_TABLES(2), .SEL_W(1), .DELAY_CYCLES(DLY)) u_main (
        .clk(clk), .rst(rst), .start(start_v[0]), .table_sel(sel_v[0]), .cmd(bus_m),
        .busy(busy_v[0]), .done(done_v[0]), .index(index_m), .err(err_v[0]));

    camera_config_sequencer #(.IDX_W(3), .NUM_TABLES(2), .SEL_W(1), .DELAY_CYCLES(DLY)) u_short (
        .clk(clk), .rst(rst), .start(start_v[1]), .table_sel(sel_v[1]), .cmd(bus_s),
        .busy(busy_v[1]), .done(done_v[1]), .index(index_s), .err(err_v[1]));

    camera_config_sequencer #(.IDX_W(8), .NUM_TABLES(1), .SEL_W(1), .DELAY_CYCLES(DLY)) u_one (
        .clk(clk), .rst(rst), .start(start_v[2]), .table_sel(sel_v[2]), .cmd(bus_i),
        .busy(busy_v[2]), .done(done_v[2]), .index(index_i), .err(err_v[2]));

    assign bus_m.cmd_ready = ready_v[0];
    assign bus_s.cmd_ready = ready_v[1];
    assign bus_i.cmd_ready = ready_v[2];

    assign valid_v[0] = bus_m.cmd_valid;
    assign valid_v[1] = bus_s.cmd_valid;
    assign valid_v[2] = bus_i.cmd_valid;
    assign addr_v[0]  = bus_m.cmd_addr;
    assign addr_v[1]  = bus_s.cmd_addr;
    assign addr_v[2]  = bus_i.cmd_addr;
    assign data_v[0]  = bus_m.cmd_data;
    assign data_v[1]  = bus_s.cmd_data;
    assign data_v[2]  = bus_i.cmd_data;
    assign idx_v[0]   = index_m;
    assign idx_v[1]   = {5'b0, index_s};
    assign idx_v[2]   = index_i;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_entry(input int sel, input int i);
        if (sel == 0 && i <= 10) return REF0[i];
        if (sel == 1 && i <= 8)  return REF1[i];
        return 16'hFFFF;
    endfunction

    function automatic bit rnd(input int rmode);
        return (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Check one cycle of outputs, then drive this cycle's inputs. A start is
    // only ever pulsed while the block should be busy, so it must be ignored.
    task automatic tick(input int w, input bit ev, input bit eb, input bit ed, input bit ee,
                        input int ei, input logic [15:0] ent, input bit rdy);
        @(negedge clk);
        check({dn[w], " valid"}, 32'(valid_v[w]), 32'(ev));
        check({dn[w], " busy"},  32'(busy_v[w]),  32'(eb));
        check({dn[w], " done"},  32'(done_v[w]),  32'(ed));
        check({dn[w], " err"},   32'(err_v[w]),   32'(ee));
        check({dn[w], " index"}, 32'(idx_v[w]),   32'(ei));
        if (ev) begin
            check({dn[w], " addr"}, 32'(addr_v[w]), 32'(ent[15:8]));
            check({dn[w], " data"}, 32'(data_v[w]), 32'(ent[7:0]));
        end
        ready_v[w] = rdy;
        start_v[w] = eb && ($urandom_range(0, 7) == 0);
        sel_v[w]   = 1'($urandom_range(0, 1));
    endtask

    // One full configuration pass. rmode: 0 ready tied high, 1 random ready,
    // 2 ready held low for the first 10 cycles of the second write.
    task automatic run_pass(input int w, input int sel, input int rmode);
        int          i;
        int          wr_no;
        int          waited;
        bit          fin;
        bit          rdy;
        logic [15:0] e;
        $display("pass: dut=%s table=%0d ready_mode=%0d", dn[w], sel, rmode);
        @(negedge clk);
        start_v[w] = 1'b1;
        sel_v[w]   = 1'(sel);
        ready_v[w] = rnd(rmode);
        if (sel >= ntab_v[w]) begin
            tick(w, 0, 0, 1, 1, 0, 16'h0000, rnd(rmode));
            tick(w, 0, 0, 1, 1, 0, 16'h0000, rnd(rmode));
            $display("end: dut=%s invalid table, err expected", dn[w]);
            return;
        end
        i = 0;
        wr_no = 0;
        fin = 1'b0;
        while (!fin) begin
            e = ref_entry(sel, i);
            tick(w, 0, 1, 0, 0, i, e, rnd(rmode));   // fetch
            tick(w, 0, 1, 0, 0, i, e, rnd(rmode));   // decode
            if (e == 16'hFFFF) begin
                tick(w, 0, 0, 1, 0, i, e, rnd(rmode));
                $display("end: dut=%s index=%0d end marker", dn[w], i);
                fin = 1'b1;
            end else begin
                if (e == 16'hFFF0) begin
                    repeat (DLY) tick(w, 0, 1, 0, 0, i, e, rnd(rmode));
                    $display("delay: dut=%s idx=%0d", dn[w], i);
                end else begin
                    waited = 0;
                    do begin
                        case (rmode)
                            0:       rdy = 1'b1;
                            2:       rdy = !(wr_no == 1 && waited < 10);
                            default: rdy = (waited >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                        endcase
                        tick(w, 1, 1, 0, 0, i, e, rdy);
                        waited++;
                    end while (!rdy);
                    $display("write: dut=%s idx=%0d addr=0x%02h data=0x%02h wait=%0d",
                             dn[w], i, e[15:8], e[7:0], waited - 1);
                    wr_no++;
                end
                if (i == max_v[w] - 1) begin
                    tick(w, 0, 0, 1, 1, i, e, rnd(rmode));
                    $display("end: dut=%s index=%0d no end marker", dn[w], i);
                    fin = 1'b1;
                end else begin
                    i++;
                end
            end
        end
    endtask

    task automatic check_reset_state(input int w);
        check({dn[w], " rst valid"}, 32'(valid_v[w]), 32'd0);
        check({dn[w], " rst busy"},  32'(busy_v[w]),  32'd0);
        check({dn[w], " rst done"},  32'(done_v[w]),  32'd0);
        check({dn[w], " rst err"},   32'(err_v[w]),   32'd0);
        check({dn[w], " rst index"}, 32'(idx_v[w]),   32'd0);
        check({dn[w], " rst addr"},  32'(addr_v[w]),  32'd0);
        check({dn[w], " rst data"},  32'(data_v[w]),  32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            sel_v[k]   = 1'b0;
            ready_v[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_state(k);
        rst = 1'b0;

        run_pass(0, 0, 0);
        run_pass(0, 0, 2);
        run_pass(0, 1, 1);

        // Reset asserted in the second cycle of the first delay entry.
        $display("reset: dut=main during delay");
        @(negedge clk);
        start_v[0] = 1'b1;
        sel_v[0]   = 1'b0;
        ready_v[0] = 1'b1;
        tick(0, 0, 1, 0, 0, 0, 16'h1280, 1'b1);
        tick(0, 0, 1, 0, 0, 0, 16'h1280, 1'b1);
        tick(0, 1, 1, 0, 0, 0, 16'h1280, 1'b1);
        tick(0, 0, 1, 0, 0, 1, 16'hFFF0, 1'b1);
        tick(0, 0, 1, 0, 0, 1, 16'hFFF0, 1'b1);
        tick(0, 0, 1, 0, 0, 1, 16'hFFF0, 1'b1);
        tick(0, 0, 1, 0, 0, 1, 16'hFFF0, 1'b1);
        #2;
        rst = 1'b1;
        start_v[0] = 1'b0;
        #1;
        check_reset_state(0);
        @(negedge clk);
        rst = 1'b0;
        run_pass(0, 0, 1);

        run_pass(2, 1, 0);
        run_pass(2, 0, 1);

        run_pass(1, 0, 1);
        run_pass(1, 1, 0);

        for (int k = 0; k < 6; k++) begin
            run_pass(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
